// File: rtl/cpu_pkg.sv
// Shared definitions for the core pipeline: default widths, the NOP encoding
// and the fetch FSM state type.
package cpu_pkg;
    localparam int PC_WIDTH_DEF   = 12;
    localparam int INSN_WIDTH_DEF = 32;

    localparam logic [31:0] NOP_INSN = 32'h0;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/ifid_latch.sv
// Pipeline register with clear-to-bubble, hold and load; clear has priority over hold.
module ifid_latch
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH   = PC_WIDTH_DEF,
    parameter int INSN_WIDTH = INSN_WIDTH_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  clear,
    input  logic [INSN_WIDTH-1:0] d_insn,
    input  logic [PC_WIDTH-1:0]   d_pc,
    output logic [INSN_WIDTH-1:0] q_insn,
    output logic [PC_WIDTH-1:0]   q_pc,
    output logic                  q_valid
);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_insn  <= INSN_WIDTH'(NOP_INSN);
            q_pc    <= '0;
            q_valid <= 1'b0;
        end else if (clear) begin
            q_insn  <= INSN_WIDTH'(NOP_INSN);
            q_pc    <= '0;
            q_valid <= 1'b0;
        end else if (!hold) begin
            q_insn  <= d_insn;
            q_pc    <= d_pc;
            q_valid <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_pc_control.sv
// Fetch stage: PC register, BOOT/RUN sequencing, flush counter and the IF/ID register.
module fetch_pc_control
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH   = PC_WIDTH_DEF,
    parameter int                  INSN_WIDTH = INSN_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [PC_WIDTH-1:0]   branch_target,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic [INSN_WIDTH-1:0] imem_q,
    output logic [INSN_WIDTH-1:0] ifid_insn,
    output logic [PC_WIDTH-1:0]   ifid_pc,
    output logic                  ifid_valid,
    output logic [15:0]           flush_count
);
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    fetch_state_t        state, state_n;
    logic [PC_WIDTH-1:0] pc, pc_n, pc_inc;
    logic [15:0]         cnt_n;
    logic                latch_clear, latch_hold;

    assign pc_inc    = pc + PC_WIDTH'(1);
    assign imem_addr = pc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            flush_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            flush_count <= cnt_n;
        end
    end

    // Priority in RUN is flush > stall > advance; BOOT ignores both requests.
    always_comb begin
        state_n     = RUN;
        pc_n        = pc;
        cnt_n       = flush_count;
        latch_clear = 1'b0;
        latch_hold  = 1'b0;
        if (state == BOOT) begin
            pc_n        = RESET_PC;
            latch_clear = 1'b1;
        end else if (flush) begin
            pc_n        = branch_target;
            latch_clear = 1'b1;
            cnt_n       = sat_inc16(flush_count);
        end else if (stall) begin
            latch_hold  = 1'b1;
        end else begin
            pc_n        = pc_inc;
        end
    end

    ifid_latch #(
        .PC_WIDTH  (PC_WIDTH),
        .INSN_WIDTH(INSN_WIDTH)
    ) u_ifid (
        .clock  (clock),
        .reset  (reset),
        .hold   (latch_hold),
        .clear  (latch_clear),
        .d_insn (imem_q),
        .d_pc   (pc_inc),
        .q_insn (ifid_insn),
        .q_pc   (ifid_pc),
        .q_valid(ifid_valid)
    );
endmodule

// File: tb/tb_fetch_pc_control.sv
// Bench for fetch_pc_control: directed scenarios with literal expectations plus
// randomized stall/flush/reset traffic compared every cycle against a behavioural model.
module tb_fetch_pc_control;
    localparam int PW = 12;
    localparam int IW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic [PW-1:0] branch_target = '0;
    logic [PW-1:0] imem_addr;
    logic [IW-1:0] imem_q;
    logic [IW-1:0] ifid_insn;
    logic [PW-1:0] ifid_pc;
    logic          ifid_valid;
    logic [15:0]   flush_count;

    logic [IW-1:0] key = '0;
    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    fetch_pc_control #(.PC_WIDTH(PW), .INSN_WIDTH(IW), .RESET_PC('0)) dut (
        .clock        (clock),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .branch_target(branch_target),
        .imem_addr    (imem_addr),
        .imem_q       (imem_q),
        .ifid_insn    (ifid_insn),
        .ifid_pc      (ifid_pc),
        .ifid_valid   (ifid_valid),
        .flush_count  (flush_count)
    );

    always #5 clock = ~clock;

    function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a, input logic [IW-1:0] k);
        return (32'h1000_0000 + 32'(a)) ^ k;
    endfunction

    assign imem_q = mem_word(imem_addr, key);

    // Behavioural reference: what fetch must present after each edge.
    bit            m_boot  = 1'b1;
    int            m_pc    = 0;
    logic [IW-1:0] m_insn  = '0;
    int            m_ifpc  = 0;
    bit            m_valid = 1'b0;
    int            m_cnt   = 0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_boot = 1'b1; m_pc = 0; m_insn = '0; m_ifpc = 0; m_valid = 1'b0; m_cnt = 0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_pc = 0; m_insn = '0; m_ifpc = 0; m_valid = 1'b0;
        end else if (flush) begin
            m_pc = int'(branch_target); m_insn = '0; m_ifpc = 0; m_valid = 1'b0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else if (!stall) begin
            m_insn  = mem_word(PW'(m_pc), key);
            m_ifpc  = (m_pc + 1) % (1 << PW);
            m_pc    = m_ifpc;
            m_valid = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            chk("model_imem_addr",  64'(imem_addr),   64'(m_pc));
            chk("model_ifid_insn",  64'(ifid_insn),   64'(m_insn));
            chk("model_ifid_pc",    64'(ifid_pc),     64'(m_ifpc));
            chk("model_ifid_valid", 64'(ifid_valid),  64'(m_valid));
            chk("model_flush_cnt",  64'(flush_count), 64'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_addr"},  64'(imem_addr),   64'h0);
        chk({tag, "_insn"},  64'(ifid_insn),   64'h0);
        chk({tag, "_pc"},    64'(ifid_pc),     64'h0);
        chk({tag, "_valid"}, 64'(ifid_valid),  64'h0);
        chk({tag, "_cnt"},   64'(flush_count), 64'h0);
    endtask

    initial begin
        #3;
        chk_reset_vals("rst_init");
        chk_en = 1'b1;
        #9 reset = 1'b1;
        tick();
        chk("boot_valid", 64'(ifid_valid), 64'h0);
        chk("boot_addr",  64'(imem_addr),  64'h0);
        tick();
        chk("f0_insn", 64'(ifid_insn), 64'h1000_0000);
        chk("f0_pc",   64'(ifid_pc),   64'h1);
        chk("f0_valid",64'(ifid_valid),64'h1);
        tick();
        chk("f1_insn", 64'(ifid_insn), 64'h1000_0001);
        chk("f1_pc",   64'(ifid_pc),   64'h2);
        tick();
        chk("f2_insn", 64'(ifid_insn), 64'h1000_0002);
        chk("f2_pc",   64'(ifid_pc),   64'h3);
        tick(); tick();
        chk("pre_stall_addr", 64'(imem_addr), 64'h5);
        stall = 1'b1;
        tick(); tick(); tick();
        chk("stall_addr",  64'(imem_addr), 64'h5);
        chk("stall_insn",  64'(ifid_insn), 64'h1000_0004);
        chk("stall_pc",    64'(ifid_pc),   64'h5);
        chk("stall_valid", 64'(ifid_valid),64'h1);
        stall = 1'b0;
        tick();
        chk("unstall_insn", 64'(ifid_insn), 64'h1000_0005);
        chk("unstall_pc",   64'(ifid_pc),   64'h6);
        tick();
        chk("pre_flush_addr", 64'(imem_addr), 64'h7);
        flush = 1'b1; branch_target = 12'h0A0;
        tick();
        chk("flush_addr",  64'(imem_addr),   64'h0A0);
        chk("flush_valid", 64'(ifid_valid),  64'h0);
        chk("flush_insn",  64'(ifid_insn),   64'h0);
        chk("flush_cnt",   64'(flush_count), 64'h1);
        flush = 1'b0;
        tick();
        chk("redir_pc",    64'(ifid_pc),    64'h0A1);
        chk("redir_valid", 64'(ifid_valid), 64'h1);
        chk("redir_insn",  64'(ifid_insn),  64'h1000_00A0);
        flush = 1'b1; stall = 1'b1; branch_target = 12'h010;
        tick();
        chk("fs_addr",  64'(imem_addr),   64'h010);
        chk("fs_valid", 64'(ifid_valid),  64'h0);
        chk("fs_cnt",   64'(flush_count), 64'h2);
        stall = 1'b0; branch_target = 12'hFFF;
        tick();
        flush = 1'b0;
        tick();
        chk("wrap_addr", 64'(imem_addr), 64'h000);
        chk("wrap_pc",   64'(ifid_pc),   64'h000);
        chk("wrap_insn", 64'(ifid_insn), 64'h1000_0FFF);
        tick();
        #2 reset = 1'b0;
        #1 chk_reset_vals("rst_async");
        #2 reset = 1'b1;
        tick();
        chk("reboot_valid", 64'(ifid_valid), 64'h0);
        chk("reboot_addr",  64'(imem_addr),  64'h0);
        tick();
        chk("reboot_insn", 64'(ifid_insn), 64'h1000_0000);
        chk("reboot_pc",   64'(ifid_pc),   64'h1);

        for (int i = 0; i < 2000; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            branch_target = PW'($urandom);
            if ($urandom_range(0, 31) == 0) key = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b0;
                #1 chk_reset_vals("rst_rand");
                #2 reset = 1'b1;
            end
            tick();
        end

        stall = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            branch_target = PW'($urandom);
            stall = $urandom_range(0, 1) == 1;
            tick();
        end
        chk("sat_cnt", 64'(flush_count), 64'hFFFF);
        flush = 1'b0; stall = 1'b0;
        tick();
        chk("sat_hold_cnt", 64'(flush_count), 64'hFFFF);
        tick(); tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
